data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 30 +++
 rtl/data_mem_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl_if
// Brief    : Command/response bundle between a requester and data_mem_ctrl.
// Revision : 1.0
// ============================================================================
interface data_mem_ctrl_if;
    logic        req;
    logic        we;
    logic        rd;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        ready;
    logic        err;

    modport master (
        output req, we, rd, size, sign, addr, wdata,
        input  rdata, busy, ready, err
    );

    modport slave (
        input  req, we, rd, size, sign, addr, wdata,
        output rdata, busy, ready, err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Wait-state data memory with byte/half/word lanes and range checks.
// Revision : 1.0
// ============================================================================
module data_mem_ctrl #(
    parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              load_w;

    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [1:0]        lane_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [32:0]       offset_w;
    logic              reject_w;
    logic [31:0]       mem_word_w;
    logic [31:0]       wword_w;
    logic [15:0]       half_w;
    logic [7:0]        byte_w;
    logic [31:0]       rd_ext_w;

    // 33-bit subtraction so an address below the base shows up in bit 32.
    assign offset_w = {1'b0, bus.addr} - {1'b0, ADDR_BASE};

    assign reject_w = (bus.we == bus.rd)
                   || (bus.size == 2'b11)
                   || offset_w[32]
                   || (offset_w >= LIMIT_BYTES)
                   || ((bus.size == 2'b01) && bus.addr[0])
                   || ((bus.size == 2'b00) && (bus.addr[1:0] != 2'b00));

    assign mem_word_w = mem_q[idx_q];
    assign half_w     = mem_word_w[{lane_q[1], 4'b0000} +: 16];
    assign byte_w     = mem_word_w[{lane_q, 3'b000} +: 8];

    always_comb begin
        wword_w = mem_word_w;
        unique case (size_q)
            2'b00:   wword_w = wdata_q;
            2'b01:   wword_w[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: wword_w[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
        endcase
    end

    always_comb begin
        rd_ext_w = mem_word_w;
        unique case (size_q)
            2'b01:   rd_ext_w = {{16{sign_q & half_w[15]}}, half_w};
            2'b10:   rd_ext_w = {{24{sign_q & byte_w[7]}}, byte_w};
            default: rd_ext_w = mem_word_w;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        load_w     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    load_w = 1'b1;
                    if (reject_w) begin
                        state_d = S_DONE;
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        err_d      = 1'b0;
                        wait_cnt_d = WAIT_INIT;
                        state_d    = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = rd_ext_w;
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            lane_q  <= 2'b00;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else if (load_w) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            sign_q  <= bus.sign;
            lane_q  <= bus.addr[1:0];
            idx_q   <= offset_w[IDX_W+1:2];
            wdata_q <= bus.wdata;
        end
    end

    // Storage is deliberately not reset; a reset landing on ACCESS cancels the write.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_ACCESS) && we_q) begin
            mem_q[idx_q] <= wword_w;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.ready = (state_q == S_DONE);
    assign bus.err   = (state_q == S_DONE) && err_q;

endmodule
`default_nettype wire
